// File: rtl/gppcu_issue_ctrl_if.sv
// gppcu_issue_ctrl_if
//   Handshake/bus bundle between the GPPCU issue sequencer and its
//   surroundings (host control, instruction memory, decoder/datapath,
//   local-memory unit).
//   slave  : seen from the sequencer (inputs iSTART..iMEM_ACK, drives o*)
//   master : seen from the environment driving the sequencer
//   oSTALL_CNT exists only when GPPCU_ISSUE_PERF_EN is defined.
interface gppcu_issue_ctrl_if #(
   parameter int AW = 8,
   parameter int IW = 32
);
   logic          iSTART;
   logic          iABORT;
   logic [AW-1:0] iBASE;
   logic [AW-1:0] iLEN;
   logic [AW-1:0] oIADDR;
   logic [IW-1:0] iIDATA;
   logic [4:0]    oOPC;
   logic [IW-1:0] oINSTR;
   logic          oISSUE;
   logic          oMEM_REQ;
   logic          iMEM_ACK;
   logic          oBUSY;
   logic          oDONE;
`ifdef GPPCU_ISSUE_PERF_EN
   logic [15:0]   oSTALL_CNT;
`endif

   modport slave (
      input  iSTART, iABORT, iBASE, iLEN, iIDATA, iMEM_ACK,
`ifdef GPPCU_ISSUE_PERF_EN
      output oSTALL_CNT,
`endif
      output oIADDR, oOPC, oINSTR, oISSUE, oMEM_REQ, oBUSY, oDONE
   );

   modport master (
      output iSTART, iABORT, iBASE, iLEN, iIDATA, iMEM_ACK,
`ifdef GPPCU_ISSUE_PERF_EN
      input  oSTALL_CNT,
`endif
      input  oIADDR, oOPC, oINSTR, oISSUE, oMEM_REQ, oBUSY, oDONE
   );
endinterface

// File: rtl/gppcu_issue_ctrl.sv
// gppcu_issue_ctrl
//   Sequencer in front of the GPPCU lanes. Fetches iLEN instruction words
//   starting at iBASE, issues each with a one-cycle oISSUE pulse, and stalls
//   for multi-cycle float ops (FP_LAT) and local-memory handshakes.
//   Ports:
//     iCLK  - clock, rising edge
//     iRST  - asynchronous active-high reset
//     bus   - gppcu_issue_ctrl_if.slave (start/abort, instruction memory,
//             decoder/datapath issue, local-memory req/ack, busy/done)
//   Optional: define GPPCU_ISSUE_PERF_EN to add bus.oSTALL_CNT, a saturating
//   count of cycles spent in WAIT_FP/WAIT_MEM since the last accepted start.
module gppcu_issue_ctrl #(
   parameter int AW     = 8,
   parameter int IW     = 32,
   parameter int FP_LAT = 4
) (
   input logic              iCLK,
   input logic              iRST,
   gppcu_issue_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_FP, WAIT_MEM, FIN} state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic [AW-1:0] count;
   logic [3:0]    waitCnt;
   logic [AW-1:0] iaddrQ;
   logic [IW-1:0] instrQ;
   logic [4:0]    opcQ;
   logic          issueQ;
   logic          memReqQ;
   logic          busyQ;
   logic          doneQ;

   logic [4:0] fetchedOpc;
   logic       isFp;
   logic       isMem;
   logic       startOk;

   assign fetchedOpc = bus.iIDATA[IW-1 -: 5];
   assign isFp       = (fetchedOpc >= 5'd11) && (fetchedOpc <= 5'd18);
   assign isMem      = (fetchedOpc >= 5'd19) && (fetchedOpc <= 5'd21);
   assign startOk    = (state == IDLE) && bus.iSTART && !bus.iABORT;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state   <= IDLE;
         pc      <= '0;
         count   <= '0;
         waitCnt <= '0;
         iaddrQ  <= '0;
         instrQ  <= '0;
         opcQ    <= '0;
         issueQ  <= 1'b0;
         memReqQ <= 1'b0;
         busyQ   <= 1'b0;
         doneQ   <= 1'b0;
      end else begin
         // issue/done are single-cycle: set only on entry to ISSUE/FIN
         issueQ <= 1'b0;
         doneQ  <= 1'b0;
         if (state != IDLE && bus.iABORT) begin
            state   <= IDLE;
            memReqQ <= 1'b0;
            busyQ   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (startOk) begin
                     busyQ <= 1'b1;
                     if (bus.iLEN != '0) begin
                        pc     <= bus.iBASE;
                        count  <= bus.iLEN;
                        iaddrQ <= bus.iBASE;
                        state  <= FETCH;
                     end else begin
                        doneQ <= 1'b1;
                        state <= FIN;
                     end
                  end
               end
               FETCH: begin
                  issueQ <= 1'b1;
                  state  <= ISSUE;
               end
               ISSUE: begin
                  // read data for the address presented in FETCH is valid now
                  instrQ <= bus.iIDATA;
                  opcQ   <= fetchedOpc;
                  pc     <= pc + AW'(1);
                  count  <= count - AW'(1);
                  if (isFp) begin
                     waitCnt <= 4'(FP_LAT - 1);
                     state   <= WAIT_FP;
                  end else if (isMem) begin
                     memReqQ <= 1'b1;
                     state   <= WAIT_MEM;
                  end else if (count != AW'(1)) begin
                     iaddrQ <= pc + AW'(1);
                     state  <= FETCH;
                  end else begin
                     doneQ <= 1'b1;
                     state <= FIN;
                  end
               end
               WAIT_FP: begin
                  if (waitCnt != 4'd0) begin
                     waitCnt <= waitCnt - 4'd1;
                  end else if (count != '0) begin
                     iaddrQ <= pc;
                     state  <= FETCH;
                  end else begin
                     doneQ <= 1'b1;
                     state <= FIN;
                  end
               end
               WAIT_MEM: begin
                  if (bus.iMEM_ACK) begin
                     memReqQ <= 1'b0;
                     if (count != '0) begin
                        iaddrQ <= pc;
                        state  <= FETCH;
                     end else begin
                        doneQ <= 1'b1;
                        state <= FIN;
                     end
                  end
               end
               FIN: begin
                  busyQ <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // An abort landing on the ISSUE/FIN cycle must swallow that cycle's pulse.
   assign bus.oISSUE   = issueQ & ~bus.iABORT;
   assign bus.oDONE    = doneQ & ~bus.iABORT;
   assign bus.oIADDR   = iaddrQ;
   assign bus.oINSTR   = instrQ;
   assign bus.oOPC     = opcQ;
   assign bus.oMEM_REQ = memReqQ;
   assign bus.oBUSY    = busyQ;

`ifdef GPPCU_ISSUE_PERF_EN
   logic [15:0] stallCnt;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         stallCnt <= '0;
      end else if (startOk) begin
         stallCnt <= '0;
      end else if ((state == WAIT_FP || state == WAIT_MEM) && stallCnt != 16'hFFFF) begin
         stallCnt <= stallCnt + 16'd1;
      end
   end

   assign bus.oSTALL_CNT = stallCnt;
`endif

endmodule

// File: tb/tb_gppcu_issue_ctrl.sv
// tb_gppcu_issue_ctrl
//   Directed programs for the issue sequencer. A trace builder turns each
//   program into a per-cycle list of inputs and expected outputs from the
//   instruction timing rules (2 cycles per plain op, FP_LAT+2 per float op,
//   ack delay + 2 per memory op); one checker process compares every cycle.
//   Literal checks on measured pulse spacing pin the model.
module tb_gppcu_issue_ctrl;
   localparam int FPL = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   gppcu_issue_ctrl_if #(.AW(8), .IW(32)) bus ();

   gppcu_issue_ctrl #(.AW(8), .IW(32), .FP_LAT(FPL)) dut (
      .iCLK(clk),
      .iRST(rst),
      .bus (bus)
   );

   // synchronous instruction memory: data for oIADDR appears one cycle later
   logic [31:0] mem [256];
   always @(posedge clk) bus.iIDATA <= mem[bus.oIADDR];

   typedef struct {
      logic        start, abort, ack;
      logic [7:0]  base, len;
      logic [7:0]  iaddr;
      logic        issue, memReq, busy, done;
      logic [4:0]  opc;
      logic [31:0] instr;
      logic [15:0] stall;
   } cyc_t;

   cyc_t tr[$];
   cyc_t expC;
   int   ackQ[$];
   logic [7:0]  mAddr  = '0;
   logic [31:0] mInstr = '0;
   logic [4:0]  mOpc   = '0;
   logic [15:0] mStall = '0;

   int total = 0;
   int bad   = 0;
   logic chk = 1'b0;
   int cyc = 0;
   int issCyc[$];
   logic [7:0] issAddr[$];
   int doneCyc, doneCnt, memCnt, startCyc;

   function automatic logic [31:0] wd(input logic [4:0] op, input logic [26:0] rest);
      return {op, rest};
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   function automatic cyc_t idleCyc();
      cyc_t c;
      c.start = 0; c.abort = 0; c.ack = 0; c.base = '0; c.len = '0;
      c.iaddr = mAddr; c.issue = 0; c.memReq = 0; c.busy = 0; c.done = 0;
      c.opc = mOpc; c.instr = mInstr; c.stall = mStall;
      return c;
   endfunction

   // Build the cycle list for one program; abortAt = cycle offset after start
   // at which iABORT is pulsed (-1 for none).
   task automatic addRun(input logic [7:0] base, input logic [7:0] len, input int abortAt);
      cyc_t c;
      int rs, k, d;
      logic [7:0] a;
      logic [31:0] w;
      c = idleCyc(); c.start = 1; c.base = base; c.len = len;
      tr.push_back(c);
      rs = tr.size();
      mStall = '0;
      a = base;
      for (int i = 0; i < int'(len); i++) begin
         mAddr = a;
         c = idleCyc(); c.busy = 1; tr.push_back(c);        // fetch
         c.issue = 1; tr.push_back(c);                       // issue
         w = mem[a]; mInstr = w; mOpc = w[31:27]; a = a + 8'd1;
         if (mOpc >= 5'd11 && mOpc <= 5'd18) begin
            for (int j = 0; j < FPL; j++) begin
               c = idleCyc(); c.busy = 1; tr.push_back(c); mStall++;
            end
         end else if (mOpc >= 5'd19 && mOpc <= 5'd21) begin
            d = ackQ.pop_front();
            for (int j = 1; j <= d; j++) begin
               c = idleCyc(); c.busy = 1; c.memReq = 1; c.ack = (j == d);
               tr.push_back(c); mStall++;
            end
         end
      end
      c = idleCyc(); c.busy = 1; c.done = 1; tr.push_back(c);
      tr.push_back(idleCyc());
      if (abortAt >= 0) begin
         k = rs + abortAt;
         mAddr = tr[k].iaddr; mInstr = tr[k].instr; mOpc = tr[k].opc;
         mStall = tr[k+1].stall;
         while (tr.size() > k + 1) void'(tr.pop_back());
         tr[k].abort = 1; tr[k].issue = 0; tr[k].done = 0; tr[k].ack = 0;
         tr.push_back(idleCyc());
      end
   endtask

   task automatic runTrace();
      foreach (tr[i]) begin
         @(posedge clk); #1;
         bus.iSTART = tr[i].start; bus.iABORT = tr[i].abort; bus.iMEM_ACK = tr[i].ack;
         bus.iBASE = tr[i].base; bus.iLEN = tr[i].len;
         expC = tr[i]; chk = 1'b1;
      end
      @(posedge clk); #1;
      chk = 1'b0;
      bus.iSTART = 0; bus.iABORT = 0; bus.iMEM_ACK = 0;
      tr.delete();
   endtask

   task automatic clearMon();
      issCyc.delete(); issAddr.delete();
      doneCyc = -1; doneCnt = 0; memCnt = 0; startCyc = -1;
   endtask

   task automatic checkAllZero(input string nm);
      cmp({nm, ".iaddr"}, 32'(bus.oIADDR), 0);
      cmp({nm, ".opc"}, 32'(bus.oOPC), 0);
      cmp({nm, ".instr"}, bus.oINSTR, 0);
      cmp({nm, ".issue"}, 32'(bus.oISSUE), 0);
      cmp({nm, ".memreq"}, 32'(bus.oMEM_REQ), 0);
      cmp({nm, ".busy"}, 32'(bus.oBUSY), 0);
      cmp({nm, ".done"}, 32'(bus.oDONE), 0);
`ifdef GPPCU_ISSUE_PERF_EN
      cmp({nm, ".stall"}, 32'(bus.oSTALL_CNT), 0);
`endif
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // per-cycle compare against the trace, plus pulse-timing monitor
   always @(posedge clk) begin
      #2;
      if (chk) begin
         cmp("iaddr", 32'(bus.oIADDR), 32'(expC.iaddr));
         cmp("issue", 32'(bus.oISSUE), 32'(expC.issue));
         cmp("opc", 32'(bus.oOPC), 32'(expC.opc));
         cmp("instr", bus.oINSTR, expC.instr);
         cmp("memreq", 32'(bus.oMEM_REQ), 32'(expC.memReq));
         cmp("busy", 32'(bus.oBUSY), 32'(expC.busy));
         cmp("done", 32'(bus.oDONE), 32'(expC.done));
`ifdef GPPCU_ISSUE_PERF_EN
         cmp("stall", 32'(bus.oSTALL_CNT), 32'(expC.stall));
`endif
         if (expC.start) startCyc = cyc;
         if (bus.oISSUE) begin issCyc.push_back(cyc); issAddr.push_back(bus.oIADDR); end
         if (bus.oDONE) begin doneCyc = cyc; doneCnt++; end
         if (bus.oMEM_REQ) memCnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.iSTART = 0; bus.iABORT = 0; bus.iMEM_ACK = 0; bus.iBASE = '0; bus.iLEN = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = wd(5'd1, 27'h123);  // MOV
      mem[8'h11] = wd(5'd3, 27'h456);  // AND
      mem[8'h12] = wd(5'd0, 27'h0);    // NOP
      mem[8'h30] = wd(5'd15, 27'h0AA); // FADD
      mem[8'h40] = wd(5'd19, 27'h0B1); // LDL
      mem[8'h41] = wd(5'd1, 27'h0B2);  // MOV
      mem[8'h50] = wd(5'd19, 27'h0C1); // LDL (aborted)
      mem[8'h51] = wd(5'd1, 27'h0C2);
      mem[8'h60] = wd(5'd2, 27'h0D1);  // aborted on issue
      mem[8'hFF] = wd(5'd1, 27'h0E1);
      mem[8'h00] = wd(5'd3, 27'h0E2);
      mem[8'h70] = wd(5'd14, 27'h0F1); // FMUL
      mem[8'h71] = wd(5'd21, 27'h0F2); // STL
      mem[8'h80] = wd(5'd15, 27'h0F3); // FADD (reset mid-wait)
      mem[8'h20] = wd(5'd25, 27'h0F4); // undefined -> NOP

      #1 rst = 1'b1;
      #2 checkAllZero("reset");
      @(negedge clk); @(negedge clk); rst = 1'b0;

      // plain ops
      clearMon(); addRun(8'h10, 8'd3, -1); runTrace();
      cmp("r1.nissue", issCyc.size(), 3);
      cmp("r1.addr0", 32'(issAddr[0]), 32'h10);
      cmp("r1.addr2", 32'(issAddr[2]), 32'h12);
      cmp("r1.gap01", issCyc[1] - issCyc[0], 2);
      cmp("r1.gap12", issCyc[2] - issCyc[1], 2);
      cmp("r1.donelat", doneCyc - issCyc[2], 1);

      // float op
      clearMon(); addRun(8'h30, 8'd1, -1); runTrace();
      cmp("r2.donelat", doneCyc - issCyc[0], 5);
      cmp("r2.memcnt", memCnt, 0);

      // local-memory op then plain op, ack 3 cycles after issue
      clearMon(); ackQ.push_back(3); addRun(8'h40, 8'd2, -1); runTrace();
      cmp("r3.memcnt", memCnt, 3);
      cmp("r3.gap", issCyc[1] - issCyc[0], 5);

      // zero-length program
      clearMon(); addRun(8'h77, 8'd0, -1); runTrace();
      cmp("r4.nissue", issCyc.size(), 0);
      cmp("r4.donelat", doneCyc - startCyc, 1);

      // abort during WAIT_MEM
      clearMon(); ackQ.push_back(5); addRun(8'h50, 8'd2, 3); runTrace();
      cmp("r5.ndone", doneCnt, 0);
      cmp("r5.memcnt", memCnt, 2);

      // abort on the issue cycle
      clearMon(); addRun(8'h60, 8'd1, 1); runTrace();
      cmp("r6.nissue", issCyc.size(), 0);
      cmp("r6.ndone", doneCnt, 0);

      // address wrap
      clearMon(); addRun(8'hFF, 8'd2, -1); runTrace();
      cmp("r7.addr0", 32'(issAddr[0]), 32'hFF);
      cmp("r7.addr1", 32'(issAddr[1]), 32'h00);

      // undefined opcode behaves as NOP
      clearMon(); addRun(8'h20, 8'd1, -1); runTrace();
      cmp("r8.donelat", doneCyc - issCyc[0], 1);

      // FMUL + STL (ack after 2), then stall counter
      clearMon(); ackQ.push_back(2); addRun(8'h70, 8'd2, -1); runTrace();
      cmp("r9.gap", issCyc[1] - issCyc[0], FPL + 2);
`ifdef GPPCU_ISSUE_PERF_EN
      cmp("r9.stall", 32'(bus.oSTALL_CNT), 6);
`endif

      // reset asserted mid-WAIT_FP: trace ends on the 2nd wait cycle
      clearMon(); addRun(8'h80, 8'd1, -1);
      while (tr.size() > 5) void'(tr.pop_back());
      runTrace();
      #2 rst = 1'b1;
      #1 checkAllZero("midrst");
      @(negedge clk); @(negedge clk); rst = 1'b0;
      mAddr = '0; mInstr = '0; mOpc = '0; mStall = '0;

      // recovery after reset
      clearMon(); addRun(8'h10, 8'd1, -1); runTrace();
      cmp("r10.nissue", issCyc.size(), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
